// File: rtl/da_ctrl.sv
// Control block for a distributed-arithmetic filter engine: loads the LUT
// coefficient set, kicks the engine once per accepted sample, collects the
// result with a completion timeout, and presents it on a ready/valid output.
module da_ctrl #(
  parameter int unsigned NCOEF   = 2048,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned ACC_W   = 38
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [19:0]      cfg_data,
  output logic             load_done,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  output logic             da_start,
  output logic             da_valid_in,
  output logic [7:0]       da_sample,
  input  logic             da_done,
  input  logic [ACC_W-1:0] da_acc,
  output logic             da_cload,
  output logic [10:0]      da_caddr,
  output logic [19:0]      da_cin,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [ACC_W-1:0] m_data,
  output logic             err
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StReady, StWait} state_e;

  state_e             state_q, state_d;
  logic [10:0]        coef_cnt_q, coef_cnt_d;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic               load_done_q, load_done_d;
  logic               da_start_q, da_start_d;
  logic               da_valid_in_q, da_valid_in_d;
  logic [7:0]         da_sample_q, da_sample_d;
  logic               da_cload_q, da_cload_d;
  logic [10:0]        da_caddr_q, da_caddr_d;
  logic [19:0]        da_cin_q, da_cin_d;
  logic               m_valid_q, m_valid_d;
  logic [ACC_W-1:0]   m_data_q, m_data_d;
  logic               err_q, err_d;
  logic               s_hs;

  // Ready flags decode straight from registered state so they are glitch-free.
  assign cfg_ready = (state_q == StLoad);
  assign s_ready   = (state_q == StReady) && !m_valid_q;
  assign s_hs      = s_valid && s_ready;

  // Next-state, counter and output-register computation.
  always_comb begin
    state_d       = state_q;
    coef_cnt_d    = coef_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    load_done_d   = load_done_q;
    da_start_d    = 1'b0;
    da_valid_in_d = 1'b0;
    da_sample_d   = da_sample_q;
    da_cload_d    = 1'b0;
    da_caddr_d    = da_caddr_q;
    da_cin_d      = da_cin_q;
    m_valid_d     = m_valid_q;
    m_data_d      = m_data_q;
    err_d         = err_q;

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (cfg_start) begin
          state_d     = StLoad;
          coef_cnt_d  = '0;
          load_done_d = 1'b0;
        end
      end
      StLoad: begin
        if (cfg_valid) begin
          da_cload_d = 1'b1;
          da_caddr_d = coef_cnt_q;
          da_cin_d   = cfg_data;
          // Last word: finish without wrapping the counter.
          if (coef_cnt_q == 11'(NCOEF - 1)) begin
            state_d     = StReady;
            load_done_d = 1'b1;
          end else begin
            coef_cnt_d = coef_cnt_q + 11'd1;
          end
        end
      end
      StReady: begin
        // A sample handshake takes priority over a reload request.
        if (s_hs) begin
          da_start_d    = 1'b1;
          da_valid_in_d = 1'b1;
          da_sample_d   = s_data;
          wait_cnt_d    = '0;
          state_d       = StWait;
        end else if (cfg_start && !m_valid_q) begin
          state_d     = StLoad;
          coef_cnt_d  = '0;
          load_done_d = 1'b0;
        end
      end
      StWait: begin
        // Completion beats a coincident timeout.
        if (da_done) begin
          m_data_d  = da_acc;
          m_valid_d = 1'b1;
          state_d   = StReady;
        end else if (wait_cnt_q == WaitW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StReady;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      coef_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      load_done_q   <= 1'b0;
      da_start_q    <= 1'b0;
      da_valid_in_q <= 1'b0;
      da_sample_q   <= '0;
      da_cload_q    <= 1'b0;
      da_caddr_q    <= '0;
      da_cin_q      <= '0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      coef_cnt_q    <= coef_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      load_done_q   <= load_done_d;
      da_start_q    <= da_start_d;
      da_valid_in_q <= da_valid_in_d;
      da_sample_q   <= da_sample_d;
      da_cload_q    <= da_cload_d;
      da_caddr_q    <= da_caddr_d;
      da_cin_q      <= da_cin_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      err_q         <= err_d;
    end
  end

  assign load_done   = load_done_q;
  assign da_start    = da_start_q;
  assign da_valid_in = da_valid_in_q;
  assign da_sample   = da_sample_q;
  assign da_cload    = da_cload_q;
  assign da_caddr    = da_caddr_q;
  assign da_cin      = da_cin_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign err         = err_q;

endmodule

// File: tb/tb_da_ctrl.sv
// Self-checking bench for da_ctrl: coefficient loads, sample transactions
// with a scripted engine response, backpressure, timeout and reset cases.
module tb_da_ctrl;

  localparam int unsigned NCOEF   = 2048;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned ACC_W   = 38;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_start, cfg_valid, cfg_ready;
  logic [19:0]      cfg_data;
  logic             load_done;
  logic             s_valid, s_ready;
  logic [7:0]       s_data;
  logic             da_start, da_valid_in;
  logic [7:0]       da_sample;
  logic             da_done;
  logic [ACC_W-1:0] da_acc;
  logic             da_cload;
  logic [10:0]      da_caddr;
  logic [19:0]      da_cin;
  logic             m_valid, m_ready;
  logic [ACC_W-1:0] m_data;
  logic             err;

  int total = 0;
  int bad   = 0;
  bit exp_err = 1'b0;  // model of the sticky error flag

  da_ctrl #(.NCOEF(NCOEF), .TIMEOUT(TIMEOUT), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_data(cfg_data), .load_done(load_done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .da_start(da_start),
    .da_valid_in(da_valid_in), .da_sample(da_sample), .da_done(da_done),
    .da_acc(da_acc), .da_cload(da_cload), .da_caddr(da_caddr), .da_cin(da_cin),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    total++;
    if ({load_done, cfg_ready, s_ready, da_start, da_valid_in, da_cload, m_valid, err} !== 8'h00) begin
      bad++;
      $display("FAIL reset_flags: got %b want 00000000",
               {load_done, cfg_ready, s_ready, da_start, da_valid_in, da_cload, m_valid, err});
    end
    total++;
    if (da_caddr !== 11'd0 || da_cin !== 20'd0 || da_sample !== 8'd0 || m_data !== '0) begin
      bad++;
      $display("FAIL reset_data: caddr=%0h cin=%0h sample=%0h m_data=%0h want all 0",
               da_caddr, da_cin, da_sample, m_data);
    end
    reset = 1'b0;
    exp_err = 1'b0;
    tick();
    total++;
    if (cfg_ready !== 1'b0 || s_ready !== 1'b0) begin
      bad++;
      $display("FAIL idle_ready: cfg_ready=%b s_ready=%b want 0 0", cfg_ready, s_ready);
    end
  endtask

  // Samples offered before any load must never reach the engine.
  task automatic test_idle_ignores_samples();
    s_valid = 1'b1;
    da_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = 8'($urandom);
      tick();
      total++;
      if (da_start !== 1'b0 || s_ready !== 1'b0 || m_valid !== 1'b0) begin
        bad++;
        $display("FAIL idle_sample: da_start=%b s_ready=%b m_valid=%b want 0 0 0",
                 da_start, s_ready, m_valid);
      end
    end
    s_valid = 1'b0;
    da_done = 1'b0;
  endtask

  // Full load from IDLE or READY; data is the address or random words.
  task automatic test_load(input bit addr_data);
    int n;
    bit hs;
    logic [19:0] d;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    total++;
    if (cfg_ready !== 1'b1 || load_done !== 1'b0) begin
      bad++;
      $display("FAIL load_entry: cfg_ready=%b load_done=%b want 1 0", cfg_ready, load_done);
    end
    n = 0;
    for (int cyc = 0; cyc < 4 * NCOEF + 64 && n < NCOEF; cyc++) begin
      hs = ($urandom_range(0, 3) != 0);
      d  = addr_data ? 20'(n) : 20'($urandom);
      cfg_valid = hs;
      cfg_data  = d;
      tick();
      total++;
      if (hs) begin
        if (da_cload !== 1'b1 || da_caddr !== 11'(n) || da_cin !== d) begin
          bad++;
          $display("FAIL load_word: cload=%b addr=%0d cin=%0h want 1 %0d %0h",
                   da_cload, da_caddr, da_cin, n, d);
        end
        n++;
        total++;
        if (load_done !== (n == NCOEF)) begin
          bad++;
          $display("FAIL load_done_timing: load_done=%b after %0d words", load_done, n);
        end
      end else if (da_cload !== 1'b0) begin
        bad++;
        $display("FAIL load_idle_pulse: da_cload=%b want 0", da_cload);
      end
    end
    cfg_valid = 1'b0;
    total++;
    if (n != NCOEF) begin
      bad++;
      $display("FAIL load_count: got %0d words want %0d", n, NCOEF);
    end
    tick();
    total++;
    if (da_cload !== 1'b0 || load_done !== 1'b1 || s_ready !== 1'b1 || cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL load_end: cload=%b load_done=%b s_ready=%b cfg_ready=%b want 0 1 1 0",
               da_cload, load_done, s_ready, cfg_ready);
    end
  endtask

  // One sample transaction. The engine answers dly cycles after da_start
  // (never if dly > TIMEOUT); the sink then stalls for hold cycles.
  task automatic sample_txn(input logic [7:0] sd, input int dly, input logic [ACC_W-1:0] acc,
                            input int hold, input bit poke);
    bit done_ok;
    total++;
    if (s_ready !== 1'b1) begin
      bad++;
      $display("FAIL txn_ready: s_ready=%b want 1", s_ready);
    end
    s_valid = 1'b1;
    s_data  = sd;
    cfg_start = poke;  // sample handshake must win over reload
    tick();
    s_valid = 1'b0;
    cfg_start = 1'b0;
    s_data  = 8'($urandom);
    total++;
    if (da_start !== 1'b1 || da_valid_in !== 1'b1 || da_sample !== sd || s_ready !== 1'b0) begin
      bad++;
      $display("FAIL txn_kick: start=%b vin=%b sample=%0h s_ready=%b want 1 1 %0h 0",
               da_start, da_valid_in, da_sample, s_ready, sd);
    end
    done_ok = (dly <= TIMEOUT);
    for (int i = 1; i <= TIMEOUT; i++) begin
      da_done   = (i == dly);
      da_acc    = (i == dly) ? acc : ACC_W'({$urandom(), $urandom()});
      cfg_start = poke & 1'($urandom);
      tick();
      da_done   = 1'b0;
      cfg_start = 1'b0;
      total++;
      if (i == dly) begin
        if (m_valid !== 1'b1 || m_data !== acc || err !== exp_err || da_start !== 1'b0) begin
          bad++;
          $display("FAIL txn_result: m_valid=%b m_data=%0h err=%b want 1 %0h %b",
                   m_valid, m_data, err, acc, exp_err);
        end
        break;
      end else if (i == TIMEOUT) begin
        exp_err = 1'b1;
        if (err !== 1'b1 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
          bad++;
          $display("FAIL txn_timeout: err=%b m_valid=%b s_ready=%b want 1 0 1",
                   err, m_valid, s_ready);
        end
      end else if (m_valid !== 1'b0 || err !== exp_err || s_ready !== 1'b0 || da_start !== 1'b0
                   || cfg_ready !== 1'b0) begin
        bad++;
        $display("FAIL txn_waiting: m_valid=%b err=%b s_ready=%b start=%b cfg_ready=%b cycle %0d",
                 m_valid, err, s_ready, da_start, cfg_ready, i);
      end
    end
    if (!done_ok) return;
    m_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      s_valid = poke;
      cfg_start = poke;
      tick();
      total++;
      if (m_valid !== 1'b1 || m_data !== acc || s_ready !== 1'b0 || da_start !== 1'b0
          || cfg_ready !== 1'b0) begin
        bad++;
        $display("FAIL txn_hold: m_valid=%b m_data=%0h s_ready=%b start=%b cfg_ready=%b want 1 %0h 0 0 0",
                 m_valid, m_data, s_ready, da_start, cfg_ready, acc);
      end
    end
    s_valid = 1'b0;
    cfg_start = 1'b0;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    total++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      bad++;
      $display("FAIL txn_release: m_valid=%b s_ready=%b want 0 1", m_valid, s_ready);
    end
  endtask

  task automatic test_sample();
    sample_txn(8'h37, 10, ACC_W'(38'h12345), 0, 1'b0);
  endtask

  task automatic test_backpressure();
    sample_txn(8'($urandom), 5, ACC_W'({$urandom(), $urandom()}), 20, 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      sample_txn(8'($urandom), $urandom_range(1, TIMEOUT - 1),
                 ACC_W'({$urandom(), $urandom()}), $urandom_range(0, 5), 1'($urandom));
      // A stray completion outside WAIT must be ignored.
      da_done = 1'b1;
      da_acc  = ACC_W'({$urandom(), $urandom()});
      tick();
      da_done = 1'b0;
      total++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
        bad++;
        $display("FAIL stray_done: m_valid=%b s_ready=%b want 0 1", m_valid, s_ready);
      end
    end
  endtask

  task automatic test_done_at_timeout();
    sample_txn(8'($urandom), TIMEOUT, ACC_W'({$urandom(), $urandom()}), 2, 1'b0);
  endtask

  task automatic test_timeout();
    sample_txn(8'($urandom), TIMEOUT + 10, '0, 0, 1'b0);
    // Error stays sticky across a later good transaction.
    sample_txn(8'($urandom), 3, ACC_W'({$urandom(), $urandom()}), 1, 1'b0);
  endtask

  task automatic test_reload();
    test_load(1'b0);
    sample_txn(8'($urandom), 7, ACC_W'({$urandom(), $urandom()}), 0, 1'b0);
  endtask

  task automatic test_reset_mid_load();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = 20'($urandom);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cfg_valid = 1'b0;
    exp_err = 1'b0;
    total++;
    if (load_done !== 1'b0 || s_ready !== 1'b0 || cfg_ready !== 1'b0 || da_cload !== 1'b0
        || err !== 1'b0 || da_caddr !== 11'd0) begin
      bad++;
      $display("FAIL midload_reset: load_done=%b s_ready=%b cfg_ready=%b cload=%b err=%b addr=%0d",
               load_done, s_ready, cfg_ready, da_cload, err, da_caddr);
    end
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 8'($urandom);
      tick();
      total++;
      if (da_start !== 1'b0) begin
        bad++;
        $display("FAIL midload_sample: da_start=%b want 0", da_start);
      end
    end
    s_valid = 1'b0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = 20'hABCDE;
    tick();
    cfg_valid = 1'b0;
    total++;
    if (da_cload !== 1'b1 || da_caddr !== 11'd0 || da_cin !== 20'hABCDE) begin
      bad++;
      $display("FAIL midload_restart: cload=%b addr=%0d cin=%0h want 1 0 abcde",
               da_cload, da_caddr, da_cin);
    end
  endtask

  initial begin
    reset = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    s_valid = 1'b0; s_data = '0; da_done = 1'b0; da_acc = '0; m_ready = 1'b0;
    test_reset();
    test_idle_ignores_samples();
    test_load(1'b1);
    test_sample();
    test_backpressure();
    test_random();
    test_done_at_timeout();
    test_timeout();
    test_reload();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/da_ctrl.md
DA_CTRL -- requirements
Module: da_ctrl

Interface
Parameters:
REQ-001 SHALL have parameter NCOEF, default 2048, giving the number of LUT words per coefficient load.
REQ-002 SHALL have parameter TIMEOUT, default 64, giving the maximum cycles to wait for da_done.
REQ-003 SHALL have parameter ACC_W, default 38, giving the accumulator width.
Ports:
REQ-004 SHALL have port clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port cfg_start, input, 1 bit: a one-cycle request to begin a coefficient load.
REQ-007 SHALL have ports cfg_valid (input, 1), cfg_ready (output, 1) and cfg_data (input, 20) forming the coefficient word stream.
REQ-008 SHALL have port load_done, output, 1 bit: high while a complete coefficient set is loaded.
REQ-009 SHALL have ports s_valid (input, 1), s_ready (output, 1) and s_data (input, 8) forming the input sample stream.
REQ-010 SHALL have ports da_start (output, 1), da_valid_in (output, 1) and da_sample (output, 8) for the per-sample kick to the DA engine.
REQ-011 SHALL have ports da_done (input, 1) and da_acc (input, ACC_W) for the engine completion and result.
REQ-012 SHALL have ports da_cload (output, 1), da_caddr (output, 11) and da_cin (output, 20) as the LUT write port.
REQ-013 SHALL have ports m_valid (output, 1), m_ready (input, 1) and m_data (output, ACC_W) forming the filter output stream.
REQ-014 SHALL have port err, output, 1 bit: sticky timeout flag.

Function
REQ-015 SHALL implement a four-state FSM with states IDLE, LOAD, READY and WAIT.
REQ-016 IDLE SHALL go to LOAD on cfg_start; READY SHALL go to LOAD on cfg_start when m_valid=0 and no s handshake occurs in that cycle; cfg_start SHALL be ignored in LOAD and WAIT.
REQ-017 On entry to LOAD, the FSM SHALL clear the word counter to 0 and clear load_done.
REQ-018 In LOAD, cfg_ready SHALL be 1; in every other state cfg_ready SHALL be 0.
REQ-019 Each cfg handshake SHALL produce, on the next cycle, a one-cycle da_cload=1 with da_caddr=counter and da_cin=cfg_data, then increment the counter.
REQ-020 The handshake at counter=NCOEF-1 SHALL move the FSM to READY and set load_done=1 in the same cycle as the final da_cload pulse; the counter SHALL not wrap.
REQ-021 s_ready SHALL be 1 only in READY with m_valid=0.
REQ-022 On an s handshake, the next cycle SHALL carry a one-cycle da_start=1 and da_valid_in=1 with da_sample=s_data, and the FSM SHALL enter WAIT with the wait counter at 0.
REQ-023 In WAIT, when da_done=1, m_data SHALL capture da_acc, m_valid SHALL be set, and the FSM SHALL return to READY.
REQ-024 In WAIT without da_done, the wait counter SHALL increment; at count TIMEOUT-1 without da_done, err SHALL be set, no output SHALL be produced, and the FSM SHALL return to READY.
REQ-025 If da_done arrives in the same cycle as the timeout, da_done SHALL win: the result is captured and err is not set.
REQ-026 da_done SHALL be ignored outside WAIT.
REQ-027 m_valid and m_data SHALL hold stable until m_ready=1; m_valid SHALL clear in the cycle after the handshake.
REQ-028 Output latency SHALL be s handshake -> da_start one cycle later -> m_valid the cycle after da_done.
REQ-029 err SHALL remain set until reset.

Reset
REQ-030 On reset=1 at a clock edge, in any state including mid-LOAD or mid-WAIT, the FSM SHALL go to IDLE and all counters SHALL clear.
REQ-031 On reset, load_done, cfg_ready, s_ready, da_start, da_valid_in, da_cload, m_valid and err SHALL go to 0, and da_caddr, da_cin, da_sample and m_data SHALL go to 0.
REQ-032 After reset, a full coefficient load SHALL be required before any sample is accepted.

Verification
REQ-033 Bench SHALL cover this load: cfg_start, then 2048 words with data=addr -> 2048 da_cload pulses with da_caddr 0..2047 and da_cin=addr, then load_done=1 and s_ready=1.
REQ-034 Bench SHALL cover a sample with engine response: s_data=0x37, da_done 10 cycles after da_start with da_acc=0x12345 -> m_data=0x12345, m_valid=1, err=0.
REQ-035 Bench SHALL cover backpressure: m_ready=0 for 20 cycles -> s_ready=0 and m_data stable throughout; with m_ready=1, m_valid clears the next cycle.
REQ-036 Bench SHALL cover timeout: da_done is never asserted -> err=1 exactly TIMEOUT cycles after entry to WAIT, no m_valid, FSM in READY.
REQ-037 Bench SHALL cover done and timeout together: da_done in the cycle at count TIMEOUT-1 -> result captured and err=0.
REQ-038 Bench SHALL cover reset mid-LOAD: reset after 100 words -> load_done=0, s_ready=0, and a new load restarts at da_caddr=0.
